// File: rtl/mux_arb_pkg.sv
// ---------------------------------------------------------------------------
// mux_arb_pkg
// Shared definitions for the two-source mux select arbiter.
//   arb_state_t      : arbiter FSM state encoding (IDLE, G0, G1)
//   MAX_HOLD_DEFAULT : default maximum number of consecutive grant cycles
//                      a source may hold while the other one waits
// ---------------------------------------------------------------------------
package mux_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      G0   = 2'd1,
      G1   = 2'd2
   } arb_state_t;

   localparam int MAX_HOLD_DEFAULT = 4;

endpackage : mux_arb_pkg

// File: rtl/arb_hold_counter.sv
// ---------------------------------------------------------------------------
// arb_hold_counter
// Counts how many cycles the arbiter has stayed in its current state.
// The count saturates at MAX_HOLD-1 so a lone requester can hold its
// grant forever without the count wrapping back to zero.
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset, clears the count
//   clear : force the count to 0 (state entry)
//   en    : advance the count by one, stopping at MAX_HOLD-1
//   count : current hold count, width clog2(MAX_HOLD)
// ---------------------------------------------------------------------------
module arb_hold_counter #(
   parameter  int MAX_HOLD = 4,
   localparam int CW       = $clog2(MAX_HOLD)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clear,
   input  logic          en,
   output logic [CW-1:0] count
);

   localparam logic [CW-1:0] COUNT_MAX = CW'(MAX_HOLD - 1);

   // Count register: reset and clear both return to zero; clear wins over
   // en so a state change always starts the new hold period at zero.
   // Incrementing stops once the count reaches its ceiling.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (en && (count != COUNT_MAX)) begin
         count <= count + CW'(1);
      end
   end

endmodule : arb_hold_counter

// File: rtl/mux_2to1.sv
// ---------------------------------------------------------------------------
// mux_2to1
// Plain combinational two-input multiplexer steered by the arbiter.
//   in0     : data from source 0
//   in1     : data from source 1
//   sel     : 0 selects in0, 1 selects in1
//   mux_out : selected data
// ---------------------------------------------------------------------------
module mux_2to1 #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] in0,
   input  logic [WIDTH-1:0] in1,
   input  logic             sel,
   output logic [WIDTH-1:0] mux_out
);

   assign mux_out = sel ? in1 : in0;

endmodule : mux_2to1

// File: rtl/mux_sel_arbiter.sv
// ---------------------------------------------------------------------------
// mux_sel_arbiter
// Round-robin arbiter for two sources sharing a mux_2to1. Every output is
// registered. A source holding its grant while the other waits is
// preempted after MAX_HOLD cycles.
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset
//   req0  : request from source 0 (mux in0)
//   req1  : request from source 1 (mux in1)
//   sel   : mux select, 0 in G0, 1 in G1, held at last value in IDLE
//   gnt0  : grant to source 0
//   gnt1  : grant to source 1
//   busy  : a grant is active
// ---------------------------------------------------------------------------
module mux_sel_arbiter
   import mux_arb_pkg::*;
#(
   parameter int MAX_HOLD = MAX_HOLD_DEFAULT
) (
   input  logic clk,
   input  logic rst_n,
   input  logic req0,
   input  logic req1,
   output logic sel,
   output logic gnt0,
   output logic gnt1,
   output logic busy
);

   localparam int CW = $clog2(MAX_HOLD);

   arb_state_t    state;
   arb_state_t    state_next;
   logic          last_q;
   logic          last_next;
   logic          sel_next;
   logic          gnt0_next;
   logic          gnt1_next;
   logic          busy_next;
   logic [CW-1:0] hold_count;
   logic          hold_max;
   logic          hold_clear;
   logic          hold_en;

   // Any change of state restarts the hold count, including a direct
   // G0<->G1 handover; otherwise the count keeps advancing.
   assign hold_clear = (state_next != state);
   assign hold_en    = !hold_clear;
   assign hold_max   = (hold_count == CW'(MAX_HOLD - 1));

   arb_hold_counter #(
      .MAX_HOLD (MAX_HOLD)
   ) u_hold_counter (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (hold_clear),
      .en    (hold_en),
      .count (hold_count)
   );

   // State and output registers. Outputs are loaded from their next-state
   // values so they switch on the same edge as the state itself. Reset
   // leaves last pointing at source 1 so source 0 wins the first contention.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= IDLE;
         sel    <= 1'b0;
         gnt0   <= 1'b0;
         gnt1   <= 1'b0;
         busy   <= 1'b0;
         last_q <= 1'b1;
      end else begin
         state  <= state_next;
         sel    <= sel_next;
         gnt0   <= gnt0_next;
         gnt1   <= gnt1_next;
         busy   <= busy_next;
         last_q <= last_next;
      end
   end

   // Next-state logic. From IDLE a lone request wins outright and a tie
   // goes to the source that was not granted last. While granted, the
   // owner keeps the grant until it drops its request, or until the other
   // source is waiting and the hold count has reached its limit.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (req0 && req1) begin
               state_next = last_q ? G0 : G1;
            end else if (req0) begin
               state_next = G0;
            end else if (req1) begin
               state_next = G1;
            end
         end
         G0: begin
            if (!req0) begin
               state_next = req1 ? G1 : IDLE;
            end else if (req1 && hold_max) begin
               state_next = G1;
            end
         end
         G1: begin
            if (!req1) begin
               state_next = req0 ? G0 : IDLE;
            end else if (req0 && hold_max) begin
               state_next = G0;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Next output values derived from the upcoming state. sel keeps its
   // previous value in IDLE so the mux output stays put between grants,
   // and last is only rewritten when a grant state is actually entered.
   always_comb begin
      gnt0_next = (state_next == G0);
      gnt1_next = (state_next == G1);
      busy_next = (state_next != IDLE);
      sel_next  = sel;
      last_next = last_q;
      if (state_next == G0) begin
         sel_next = 1'b0;
      end else if (state_next == G1) begin
         sel_next = 1'b1;
      end
      if (state_next != state) begin
         if (state_next == G0) begin
            last_next = 1'b0;
         end else if (state_next == G1) begin
            last_next = 1'b1;
         end
      end
   end

endmodule : mux_sel_arbiter

// File: tb/tb_mux_sel_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mux_sel_arbiter
// Directed bench for mux_sel_arbiter driving a mux_2to1 (MAX_HOLD = 4).
// Expected values are hand-derived per cycle; mux_out is checked end to
// end through the arbiter-driven select.
// ---------------------------------------------------------------------------
module tb_mux_sel_arbiter;

   localparam logic [7:0] IN0_DATA = 8'hA5;
   localparam logic [7:0] IN1_DATA = 8'h3C;

   logic       clk;
   logic       rst_n;
   logic       req0;
   logic       req1;
   logic       sel;
   logic       gnt0;
   logic       gnt1;
   logic       busy;
   logic [7:0] in0;
   logic [7:0] in1;
   logic [7:0] mux_out;

   int checks;
   int errors;

   mux_sel_arbiter #(
      .MAX_HOLD (4)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .req0  (req0),
      .req1  (req1),
      .sel   (sel),
      .gnt0  (gnt0),
      .gnt1  (gnt1),
      .busy  (busy)
   );

   mux_2to1 #(
      .WIDTH (8)
   ) u_mux (
      .in0     (in0),
      .in1     (in1),
      .sel     (sel),
      .mux_out (mux_out)
   );

   // Free-running 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Checks every arbiter output plus the mux data for one cycle.
   task automatic checkAll(input string tag, input logic e_gnt0,
                           input logic e_gnt1, input logic e_sel);
      checkOutput({tag, ".gnt0"}, 32'(gnt0), 32'(e_gnt0));
      checkOutput({tag, ".gnt1"}, 32'(gnt1), 32'(e_gnt1));
      checkOutput({tag, ".sel"},  32'(sel),  32'(e_sel));
      checkOutput({tag, ".busy"}, 32'(busy), 32'(e_gnt0 | e_gnt1));
      checkOutput({tag, ".excl"}, 32'(gnt0 & gnt1), 32'd0);
      checkOutput({tag, ".mux"},  32'(mux_out), 32'(e_sel ? IN1_DATA : IN0_DATA));
   endtask

   // Drives inputs for the next rising edge, then waits until just after
   // that edge so outputs are sampled away from it.
   task automatic applyStimulus(input logic r_n, input logic r0, input logic r1);
      rst_n = r_n;
      req0  = r0;
      req1  = r1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      in0    = IN0_DATA;
      in1    = IN1_DATA;
      rst_n  = 1'b0;
      req0   = 1'b0;
      req1   = 1'b0;

      $display("[TB] reset with both requests high");
      for (int i = 0; i < 2; i++) begin
         applyStimulus(1'b0, 1'b1, 1'b1);
         checkAll("reset", 1'b0, 1'b0, 1'b0);
         checkOutput("reset.last", 32'(dut.last_q), 32'd1);
         checkOutput("reset.count", 32'(dut.hold_count), 32'd0);
      end

      // Release with both requests held: G0 x4, G1 x4, G0 x4.
      $display("[TB] contention round robin");
      for (int i = 1; i <= 12; i++) begin
         logic e0;
         e0 = (i <= 4) || (i >= 9);
         applyStimulus(1'b1, 1'b1, 1'b1);
         checkAll($sformatf("contend%0d", i), e0, !e0, !e0);
         if (i == 4) checkOutput("contend.count_max", 32'(dut.hold_count), 32'd3);
         if (i == 5) checkOutput("contend.count_clr", 32'(dut.hold_count), 32'd0);
      end

      // Both drop while in G0: back to IDLE with sel held at 0.
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkAll("idle0", 1'b0, 1'b0, 1'b0);

      $display("[TB] single requester on source 1");
      for (int i = 1; i <= 10; i++) begin
         applyStimulus(1'b1, 1'b0, 1'b1);
         checkAll($sformatf("single%0d", i), 1'b0, 1'b1, 1'b1);
      end
      checkOutput("single.saturate", 32'(dut.hold_count), 32'd3);
      for (int i = 11; i <= 12; i++) begin
         applyStimulus(1'b1, 1'b0, 1'b0);
         checkAll($sformatf("single_idle%0d", i), 1'b0, 1'b0, 1'b1);
      end

      // last = 1, so a tie goes to source 0; drop req0 at hold count 1.
      $display("[TB] early release handover");
      applyStimulus(1'b1, 1'b1, 1'b1);
      checkAll("early0", 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b1);
      checkAll("early1", 1'b1, 1'b0, 1'b0);
      checkOutput("early.count1", 32'(dut.hold_count), 32'd1);
      applyStimulus(1'b1, 1'b0, 1'b1);
      checkAll("early_hand", 1'b0, 1'b1, 1'b1);
      checkOutput("early.count0", 32'(dut.hold_count), 32'd0);

      // Stay in G1 until hold count 2, then pulse reset for one edge.
      $display("[TB] reset mid grant");
      applyStimulus(1'b1, 1'b0, 1'b1);
      applyStimulus(1'b1, 1'b0, 1'b1);
      checkAll("midgrant", 1'b0, 1'b1, 1'b1);
      checkOutput("midgrant.count2", 32'(dut.hold_count), 32'd2);
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkAll("midreset", 1'b0, 1'b0, 1'b0);
      checkOutput("midreset.last", 32'(dut.last_q), 32'd1);
      checkOutput("midreset.count", 32'(dut.hold_count), 32'd0);
      applyStimulus(1'b1, 1'b1, 1'b1);
      checkAll("restart", 1'b1, 1'b0, 1'b0);
      checkOutput("restart.last", 32'(dut.last_q), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_mux_sel_arbiter

// File: doc/mux_sel_arbiter.md
MUX_SEL_ARBITER -- requirements
Module: mux_sel_arbiter

Interface
REQ-001 The block SHALL have parameter MAX_HOLD, default 4, giving the maximum number of consecutive grant cycles while the other requester waits; legal range is 2..255.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 req0  input  1  request from source 0, i.e. the driver of mux in0.
REQ-005 req1  input  1  request from source 1, i.e. the driver of mux in1.
REQ-006 sel  output  1  select line driven directly into the downstream mux_2to1 sel port; 0 selects in0, 1 selects in1.
REQ-007 gnt0  output  1  grant to source 0.
REQ-008 gnt1  output  1  grant to source 1.
REQ-009 busy  output  1  high whenever a grant is active.

Function
REQ-010 The block SHALL be a registered FSM with states IDLE, G0 and G1; every output SHALL come from a flop.
REQ-011 gnt0 SHALL be 1 only in G0, gnt1 only in G1, and busy SHALL equal (state != IDLE); gnt0 and gnt1 SHALL never both be 1.
REQ-012 sel SHALL be 0 in G0 and 1 in G1, and SHALL hold its last value in IDLE so the mux output does not toggle between grants.
REQ-013 A 1-bit last register SHALL record the most recently granted source and update on every entry to G0 or G1.
REQ-014 IDLE, req0 only: next state G0.
REQ-015 IDLE, req1 only: next state G1.
REQ-016 IDLE, both requests: next state is the source not equal to last (round-robin).
REQ-017 IDLE, no request: stay in IDLE.
REQ-018 Grant latency SHALL be exactly 1 cycle: a request sampled at edge N in IDLE gives its grant high after edge N.
REQ-019 A hold counter of width clog2(MAX_HOLD) SHALL clear to 0 on every state entry, including direct G0<->G1 transitions, and increment each cycle the state is unchanged.
REQ-020 In G0, if req0 is low and req1 is high, the next state SHALL be G1.
REQ-021 In G0, if req0 is low and req1 is low, the next state SHALL be IDLE.
REQ-022 In G0, if req0 and req1 are both high and the counter equals MAX_HOLD-1, the next state SHALL be G1 (preemption).
REQ-023 In G0, in all other cases the state SHALL stay G0.
REQ-024 G1 SHALL behave as the mirror of G0 (REQ-020..023) with the roles of req0/req1 swapped.
REQ-025 With a single requester holding its request, the grant SHALL persist indefinitely and the counter SHALL saturate at MAX_HOLD-1 with no wrap.
REQ-026 A G0->G1 or G1->G0 handover SHALL take one edge with no IDLE cycle; sel and the grants SHALL switch on the same edge.

Reset
REQ-027 While rst_n is low at a rising edge, the next state SHALL be: state=IDLE, sel=0, gnt0=0, gnt1=0, busy=0, counter=0, last=1 (so source 0 wins the first contention).
REQ-028 Reset asserted mid-grant SHALL drop the grant on that edge; there is no drain.
REQ-029 Requests present when rst_n deasserts SHALL be arbitrated per REQ-014..016 starting at the first edge with rst_n high.

Structure
REQ-030 A shared package mux_arb_pkg SHALL hold the state enumeration (IDLE, G0, G1) and the MAX_HOLD default constant.
REQ-031 The hold counter SHALL be a sub-module arb_hold_counter with ports clk, rst_n, clear, en and count, parameterised by MAX_HOLD, with saturation built in.
REQ-032 The bench SHALL instantiate mux_arb_pkg users together with mux_2to1, connecting arbiter sel to mux sel, so that mux_out is checked end to end.

Verification (MAX_HOLD=4)
REQ-033 Reset: hold rst_n=0 for 2 edges with req0=req1=1 -> all outputs 0; the first edge after release gives gnt0=1, sel=0.
REQ-034 Single requester: req1=1 for 10 cycles, then 0 -> gnt1=1 and sel=1 from edge 1 through edge 10; IDLE at edge 11; sel stays 1 while in IDLE.
REQ-035 Contention fairness: req0=req1=1 held continuously -> the grant alternates G0,G1,G0 with 4 cycles each; never both grants high.
REQ-036 Early release: in G0 with req1=1, drop req0 at hold count 1 -> G1 on the next edge with no IDLE cycle; mux_out follows in1 from that edge.
REQ-037 Reset mid-grant: in G1 at hold count 2, pulse rst_n=0 for 1 edge -> gnt1=0, sel=0 and last=1 on that edge; arbitration restarts cleanly.
